// File: rtl/gdp_sched.sv
// gdp_sched: round-robin job scheduler in front of a single summation engine.
// Four requesters raise level requests; one winner at a time is granted, its
// operand is latched onto eng_n, the engine is run until it reports done or a
// timeout expires, and the result is returned as a one-cycle response pulse.
// After every job the engine is held idle for RECOVER cycles.
//
// Handshake: req[i] is a level held by requester i until it sees gnt[i] (a
// one-cycle pulse); a req dropped before its gnt is simply never granted.
// rsp_valid[i] is a one-cycle pulse that qualifies rsp_sum/rsp_err, which then
// hold their value until the next response. eng_go is a level: the engine runs
// while it is high, and eng_done/eng_sum are only looked at while waiting.
module gdp_sched #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned RECOVER = 2
) (
  input  logic        clk,
  input  logic        restart,
  input  logic [3:0]  req,
  input  logic [31:0] n_in,
  output logic [3:0]  gnt,
  output logic [3:0]  rsp_valid,
  output logic [7:0]  rsp_sum,
  output logic        rsp_err,
  output logic [7:0]  eng_n,
  output logic        eng_go,
  input  logic [7:0]  eng_sum,
  input  logic        eng_done,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    RCVR  = 3'd4
  } state_t;

  localparam logic [7:0] TOUT     = TIMEOUT[7:0];
  localparam logic [2:0] RCV_LAST = 3'(RECOVER - 1);

  state_t     state, state_d;
  logic [1:0] ptr;
  logic [1:0] win;
  logic [7:0] cnt;
  logic [2:0] rcnt;
  logic       pick_found;
  logic [1:0] pick_idx;
  logic [7:0] cnt_next;
  logic       tout_hit;
  logic [3:0] win_oh;

  assign cnt_next  = cnt + 8'd1;
  assign tout_hit  = (cnt_next == TOUT);
  assign win_oh    = 4'b0001 << win;
  assign dbg_state = state;

  // Round-robin search: first requesting index starting at ptr, wrapping mod 4.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] cand;
      cand = ptr + 2'(i);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // State register; restart returns to IDLE immediately.
  always_ff @(posedge clk or negedge restart) begin
    if (!restart) state <= IDLE;
    else          state <= state_d;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d   = state;
    gnt       = 4'b0000;
    rsp_valid = 4'b0000;
    eng_go    = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (pick_found) state_d = ISSUE;
      end
      ISSUE: begin
        gnt     = win_oh;
        eng_go  = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        eng_go = 1'b1;
        if (eng_done || tout_hit) state_d = RESP;
      end
      RESP: begin
        rsp_valid = win_oh;
        state_d   = RCVR;
      end
      RCVR: begin
        if (rcnt == RCV_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Job datapath: winner/operand latch, wait counter, result capture, pointer.
  always_ff @(posedge clk or negedge restart) begin
    if (!restart) begin
      ptr     <= 2'd0;
      win     <= 2'd0;
      cnt     <= 8'd0;
      rcnt    <= 3'd0;
      eng_n   <= 8'd0;
      rsp_sum <= 8'd0;
      rsp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            win   <= pick_idx;
            eng_n <= n_in[8*pick_idx +: 8];
          end
        end
        ISSUE: cnt <= 8'd0;
        WAIT: begin
          cnt <= cnt_next;
          // A done seen on the final wait cycle still counts as success.
          if (eng_done) begin
            rsp_sum <= eng_sum;
            rsp_err <= 1'b0;
          end else if (tout_hit) begin
            rsp_sum <= 8'd0;
            rsp_err <= 1'b1;
          end
        end
        RESP: begin
          ptr  <= win + 2'd1;
          rcnt <= 3'd0;
        end
        RCVR: rcnt <= rcnt + 3'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gdp_sched.sv
// tb_gdp_sched: directed and randomized checks of gdp_sched against a
// timestamp-based reference model of the scheduling rules.
module tb_gdp_sched;

  localparam int TO = 20;
  localparam int RC = 3;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        restart;
  logic [3:0]  req = 4'd0;
  logic [31:0] n_in = 32'd0;
  logic [7:0]  eng_sum = 8'd0;
  logic        eng_done = 1'b0;
  logic [3:0]  gnt, rsp_valid;
  logic [7:0]  rsp_sum, eng_n;
  logic        rsp_err, eng_go, busy;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  gdp_sched #(.TIMEOUT(TO), .RECOVER(RC)) dut (
    .clk(clk), .restart(restart), .req(req), .n_in(n_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_err(rsp_err),
    .eng_n(eng_n), .eng_go(eng_go), .eng_sum(eng_sum), .eng_done(eng_done),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- requester / engine stimulus state ----------------
  logic [3:0] pend     = 4'd0;
  logic [7:0] opnd[4]  = '{8'd0, 8'd0, 8'd0, 8'd0};
  int         lat[4]   = '{0, 0, 0, 0};
  bit         hold_req = 1'b0;
  int         gnt_log[$];

  // ---------------- reference model state ----------------
  int         cyc        = 0;
  bit         job_active = 1'b0;
  int         g_cyc = 0, r_cyc = 0, idle_from = 0;
  int         exp_idx = 0;
  logic [7:0] exp_sum = 8'd0, last_sum = 8'd0, last_engn = 8'd0;
  logic       exp_err = 1'b0, last_err = 1'b0;
  logic [1:0] mptr = 2'd0;
  int         elat = 0, ecyc = 0;
  logic [3:0] exp_gnt, exp_rv;
  logic       exp_go, exp_busy;
  int         gidx, w;

  function automatic int rr_pick(input logic [3:0] r, input logic [1:0] p);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (int'(p) + k) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  // The engine sums 1..n.
  function automatic logic [7:0] tri_sum(input logic [7:0] n);
    int s;
    s = int'(n) * (int'(n) + 1) / 2;
    return 8'(s);
  endfunction

  // Per-cycle model, engine and requester driver, all on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!restart) begin
      check("reset_outs", {5'd0, gnt, rsp_valid, eng_go, busy, rsp_err, rsp_sum, eng_n}, 32'd0);
      job_active = 1'b0;
      mptr       = 2'd0;
      last_sum   = 8'd0;
      last_err   = 1'b0;
      last_engn  = 8'd0;
      idle_from  = 0;
      ecyc       = 0;
      eng_done   = 1'b0;
      req        = pend;
      n_in       = {opnd[3], opnd[2], opnd[1], opnd[0]};
    end else begin
      exp_gnt = (job_active && cyc == g_cyc) ? (4'b0001 << exp_idx) : 4'b0000;
      exp_rv  = 4'b0000;
      if (job_active && cyc == r_cyc) begin
        exp_rv   = 4'b0001 << exp_idx;
        last_sum = exp_sum;
        last_err = exp_err;
      end
      exp_go   = job_active && cyc >= g_cyc && cyc < r_cyc;
      exp_busy = job_active && cyc >= g_cyc && cyc <= r_cyc + RC;
      check("gnt", gnt, exp_gnt);
      check("rsp_valid", rsp_valid, exp_rv);
      check("eng_go", eng_go, exp_go);
      check("busy", busy, exp_busy);
      check("rsp_sum", rsp_sum, last_sum);
      check("rsp_err", rsp_err, last_err);
      check("eng_n", eng_n, last_engn);
      if ($onehot(gnt)) begin
        gidx = 0;
        for (int i = 0; i < 4; i++) if (gnt[i]) gidx = i;
        gnt_log.push_back(gidx);
      end
      if (job_active && cyc == r_cyc + RC) begin
        job_active = 1'b0;
        idle_from  = cyc + 1;
      end
      // engine: done after elat cycles of eng_go high; elat==0 never finishes
      if (eng_go) begin
        ecyc++;
        eng_done = (elat != 0) && (ecyc >= elat);
      end else begin
        ecyc     = 0;
        eng_done = 1'b0;
      end
      eng_sum = eng_done ? tri_sum(eng_n) : 8'($urandom);
      // requesters
      req  = pend;
      n_in = {opnd[3], opnd[2], opnd[1], opnd[0]};
      if (!job_active && cyc >= idle_from && req != 4'd0) begin
        w          = rr_pick(req, mptr);
        job_active = 1'b1;
        g_cyc      = cyc + 1;
        exp_idx    = w;
        last_engn  = opnd[w];
        elat       = lat[w];
        if (elat >= 2 && elat <= TO + 1) begin
          r_cyc   = g_cyc + elat;
          exp_sum = tri_sum(opnd[w]);
          exp_err = 1'b0;
        end else begin
          r_cyc   = g_cyc + TO + 1;
          exp_sum = 8'd0;
          exp_err = 1'b1;
        end
        mptr = 2'(w + 1);
        if (!hold_req) pend[w] = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    tick();
    restart = 1'b0;
    repeat (2) tick();
    restart = 1'b1;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((job_active || pend != 4'd0) && k < budget) begin
      tick();
      k++;
    end
    check("drain", (job_active || pend != 4'd0) ? 1 : 0, 0);
  endtask

  task automatic wait_in_wait(input int budget);
    int k = 0;
    while (!(job_active && cyc >= g_cyc + 2 && cyc + 1 < r_cyc) && k < budget) begin
      tick();
      k++;
    end
    check("reach_wait", (job_active && cyc >= g_cyc + 2) ? 1 : 0, 1);
  endtask

  task automatic wait_grants(input int n, input int budget);
    int k = 0;
    while (gnt_log.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("grant_count", gnt_log.size(), n);
  endtask

  // Hard stop in case anything hangs.
  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int order[5];
    order = '{0, 1, 2, 3, 0};
    restart = 1'b0;
    repeat (3) tick();
    restart = 1'b1;

    // single job: operand 5, engine returns 15 after 10 cycles
    opnd[0] = 8'd5; lat[0] = 10; pend = 4'b0001;
    drain(200);
    check("single_sum", rsp_sum, 8'd15);
    check("single_err", rsp_err, 1'b0);
    check("single_engn", eng_n, 8'd5);

    // contention from ptr=0 with all four held
    do_reset();
    for (int i = 0; i < 4; i++) begin
      opnd[i] = 8'($urandom);
      lat[i]  = $urandom_range(2, TO + 1);
    end
    gnt_log.delete();
    hold_req = 1'b1;
    pend     = 4'hf;
    wait_grants(5, 2000);
    hold_req = 1'b0;
    pend     = 4'd0;
    drain(500);
    for (int i = 0; i < 5; i++)
      check("rr_order", (i < gnt_log.size()) ? gnt_log[i] : -1, order[i]);

    // timeout: engine never finishes
    opnd[2] = 8'd44; lat[2] = 0; pend = 4'b0100;
    drain(300);
    check("tout_err", rsp_err, 1'b1);
    check("tout_sum", rsp_sum, 8'd0);

    // done on the same cycle the counter expires: done wins
    opnd[3] = 8'd8; lat[3] = TO + 1; pend = 4'b1000;
    drain(300);
    check("tie_err", rsp_err, 1'b0);
    check("tie_sum", rsp_sum, 8'd36);

    // operand isolation: n_in[15:8] changes 7 -> 9 mid-job
    opnd[1] = 8'd7; lat[1] = 15; pend = 4'b0010;
    wait_in_wait(100);
    opnd[1] = 8'd9;
    drain(300);
    check("iso_engn", eng_n, 8'd7);
    check("iso_sum", rsp_sum, 8'd28);

    // reset during WAIT, then 1010 requesting
    opnd[0] = 8'd3; lat[0] = 0; pend = 4'b0001;
    wait_in_wait(100);
    restart = 1'b0;
    #1;
    check("rst_async_outs", {5'd0, gnt, rsp_valid, eng_go, busy, rsp_err, rsp_sum, eng_n}, 32'd0);
    repeat (2) tick();
    opnd[1] = 8'd11; opnd[3] = 8'd12; lat[1] = 4; lat[3] = 6;
    pend = 4'b1010;
    gnt_log.delete();
    tick();
    restart = 1'b1;
    drain(500);
    check("rst_first_gnt", (gnt_log.size() > 0) ? gnt_log[0] : -1, 1);

    // randomized traffic, including drops of pending requests
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          opnd[i] = 8'($urandom);
          lat[i]  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(2, TO + 1);
          pend[i] = 1'b1;
        end
      end
      if ($urandom_range(0, 7) == 0) pend = pend & 4'($urandom);
      repeat ($urandom_range(1, 30)) tick();
    end
    drain(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
